vga_timing_tx: RTL
==================

# vga_timing_tx

Transmit end of the board's VGA path: generates pixel-rate timing, horizontal and vertical sync, and blanking from `CLOCK_50`. It requests pixel colour from an upstream generator by screen coordinate and drives the DE1-SoC video DAC pins, `VGA_*`, with aligned, registered outputs. It sits in `top` next to the key/switch input logic and is the board's only video output driver.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; must be ≥1. 2 gives 25 MHz pixels from 50 MHz.
- `H_ACTIVE` / `H_FP` / `H_SYNC` / `H_BP`, 640 / 16 / 96 / 48: horizontal timing, in pixels.
- `V_ACTIVE` / `V_FP` / `V_SYNC` / `V_BP`, 480 / 10 / 2 / 33: vertical timing, in lines.
- `SYNC_POL`, 0: sync pulse level; 0 means active-low.
- `CLOCK_50` in 1: system clock; all logic runs on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low; the only reset.
- `pix_x` out 10: current pixel column (the h counter).
- `pix_y` out 10: current line (the v counter).
- `pix_req` out 1: high when (`pix_x`, `pix_y`) is inside the active area.
- `pix_rgb` in 24: {R,G,B}, 8 bits each; must be valid for the coordinate on `pix_x`/`pix_y` by the pixel tick.
- `frame_start` out 1: one-clock pulse on the tick that wraps the counters to (0,0).
- `VGA_CLK` out 1: pixel clock to the DAC.
- `VGA_HS`, `VGA_VS` out 1: sync outputs.
- `VGA_BLANK_N` out 1: low while blanked.
- `VGA_SYNC_N` out 1: constant 0.
- `VGA_R`, `VGA_G`, `VGA_B` out 8 each: colour outputs.

## Operation
- **Derived values.** `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` (800). `V_TOTAL` is defined the same way (525). Counters are 10 bits; elaboration fails if `H_TOTAL` or `V_TOTAL` exceeds 1024.
- **Divider.**
  - `div_cnt` counts 0..`CLK_DIV`-1 and wraps.
  - tick = (`div_cnt == CLK_DIV-1`).
  - With `CLK_DIV=1`, tick is 1 every cycle.
- **Counters.** On tick:
  - `h_cnt` increments; at `H_TOTAL-1` it wraps to 0.
  - On that wrap, `v_cnt` increments; at `V_TOTAL-1` it wraps to 0.
  - Counters change only on tick.
- **Request side (combinational from the counters).**
  - `pix_x = h_cnt`, `pix_y = v_cnt`.
  - `pix_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`.
- **Output stage.** Registered, loaded on tick from the current counters:
  - `VGA_BLANK_N <= pix_req`.
  - `{VGA_R,VGA_G,VGA_B} <= pix_req ? pix_rgb : 0`.
  - `VGA_HS <= (h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)) ? SYNC_POL : ~SYNC_POL`.
  - `VGA_VS` uses the same rule on `v_cnt` with the V parameters.
- **`frame_start`.** Registered; 1 for exactly one clock, in the cycle after the tick where `h_cnt==H_TOTAL-1` and `v_cnt==V_TOTAL-1`.
- **`VGA_CLK`.**
  - `CLK_DIV ≥ 2`: registered; 1 when `div_cnt ≥ CLK_DIV/2` (integer division), else 0.
  - `CLK_DIV=1`: `VGA_CLK = ~CLOCK_50`.
- **Reset (asynchronous, while `rst_n` = 0).**
  - `div_cnt`, `h_cnt`, `v_cnt` = 0, so `pix_x`=0, `pix_y`=0, `pix_req`=1.
  - `VGA_HS` = `VGA_VS` = `~SYNC_POL` (1 by default).
  - `VGA_BLANK_N`=0, RGB=0, `frame_start`=0, `VGA_CLK`=0, `VGA_SYNC_N`=0.
- **Reset mid-frame.** Every output takes its reset value immediately. After release, the first tick comes `CLK_DIV` clocks later, and the frame restarts at (0,0). No partial-line recovery.
- **Flow control.** `pix_rgb` has no handshake or back-pressure. The upstream generator must meet the pixel-period deadline; `pix_rgb` is ignored when `pix_req`=0.

## Timing
- **Pixel period.** `CLK_DIV` clocks. `pix_x`/`pix_y` are stable for the whole period, giving `CLK_DIV` clocks of upstream combinational or registered slack.
- **Latency.** The video outputs lag the counters by exactly one pixel period. HS, VS, BLANK_N and RGB for coordinate (x,y) all appear together in the period after the counters show (x,y).
- **`VGA_CLK` edge (`CLK_DIV=2`).** It rises one system clock after the outputs update, i.e. mid-pixel, where the DAC samples.
- **Line period.** 800 ticks = 1600 clocks: 32 µs, 31.25 kHz.
- **Frame period.** 420 000 ticks = 840 000 clocks, about 59.52 Hz.
- **Default sync windows.**
  - hsync: `h_cnt` 656–751.
  - vsync: `v_cnt` 490–491.

## Test plan
- **Reset values.** Hold `rst_n`=0 for 5 clocks -> `VGA_HS`=1, `VGA_VS`=1, `VGA_BLANK_N`=0, RGB=0, `pix_x`=`pix_y`=0, `pix_req`=1, `frame_start`=0.
- **Horizontal timing (defaults).** Release reset, count clocks -> `VGA_HS` falls every 1600 clocks, low for 192 clocks; `VGA_BLANK_N` is high for 1280 clocks per line during `v_cnt` <480.
- **Vertical timing and frame.** Run 2 frames -> `frame_start` pulses exactly every 840 000 clocks; `VGA_VS` is low for 3200 clocks per frame, starting 490×1600 clocks after the frame starts.
- **Data path.** `pix_rgb = {pix_x[7:0], pix_y[7:0], 8'hA5}`:
  - at output (x=5, y=3) -> RGB = 05/03/A5, one pixel period after `pix_x`=5.
  - at `pix_x`=640 -> RGB=0 and `BLANK_N`=0 regardless of `pix_rgb`.
- **Reset mid-frame.** Assert `rst_n`=0 at (x=300, y=200) for 3 clocks -> outputs go to reset values asynchronously; after release, `pix_x` reaches 1 after 2 clocks, and the next `frame_start` comes 840 000 clocks after release.
- **`CLK_DIV=1`, `SYNC_POL=1`.** -> hsync period is 800 clocks; `VGA_HS` is high for 96 clocks and idles at 0 (reset value 0).

Source files
------------

// File: rtl/vga_timing_tx.sv
// vga_timing_tx: pixel-rate timing, sync and blanking with registered DAC outputs.
// Ports: CLOCK_50, rst_n in; pix_x/pix_y/pix_req/frame_start out; pix_rgb in; VGA_* out.
`timescale 1ns/1ps
module vga_timing_tx #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        CLOCK_50,
  input  logic        rst_n,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic        pix_req,
  input  logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        VGA_CLK,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $error("vga_timing_tx: H_TOTAL/V_TOTAL exceed 10-bit counters");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_tx: CLK_DIV must be >= 1");
  end

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a window ending exactly at 1024 still compares correctly
  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             w_tick;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic [10:0]      w_h11;
  logic [10:0]      w_v11;
  logic             w_h_last;
  logic             w_v_last;
  logic             w_req;
  logic             w_hs_on;
  logic             w_vs_on;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;
  logic             r_fs;
  logic [23:0]      r_rgb;

  assign w_tick    = (r_div == DIV_MAX);
  assign w_div_nxt = w_tick ? '0 : r_div + 1'b1;
  assign w_h_last  = (r_h == H_LAST);
  assign w_v_last  = (r_v == V_LAST);
  assign w_h11     = {1'b0, r_h};
  assign w_v11     = {1'b0, r_v};
  assign w_req     = (w_h11 < H_ACT) && (w_v11 < V_ACT);
  assign w_hs_on   = (w_h11 >= HS_BEG) && (w_h11 < HS_END);
  assign w_vs_on   = (w_v11 >= VS_BEG) && (w_v11 < VS_END);

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_div_nxt;
      if (w_tick) begin
        r_h <= w_h_last ? '0 : r_h + 10'd1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 10'd1;
        end
      end
    end
  end

  // Video outputs capture the current coordinate, so they trail it by one pixel.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_hs      <= ~SYNC_POL;
      r_vs      <= ~SYNC_POL;
      r_blank_n <= 1'b0;
      r_rgb     <= '0;
      r_fs      <= 1'b0;
    end else begin
      r_fs <= w_tick && w_h_last && w_v_last;
      if (w_tick) begin
        r_blank_n <= w_req;
        r_rgb     <= w_req ? pix_rgb : '0;
        r_hs      <= w_hs_on ? SYNC_POL : ~SYNC_POL;
        r_vs      <= w_vs_on ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

  if (CLK_DIV == 1) begin : g_vclk_pass
    assign VGA_CLK = ~CLOCK_50;
  end else begin : g_vclk_reg
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    logic r_vclk;
    // Built from the next divider value so the rising edge lands mid-pixel.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        r_vclk <= 1'b0;
      end else begin
        r_vclk <= (w_div_nxt >= DIV_HALF);
      end
    end
    assign VGA_CLK = r_vclk;
  end

  assign pix_x       = r_h;
  assign pix_y       = r_v;
  assign pix_req     = w_req;
  assign frame_start = r_fs;
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];

endmodule
